vscale_mem_arbiter: RTL
=======================

Name: vscale_mem_arbiter

Overview:
- Shares one pipelined single-port backing memory between the core's instruction port (i) and data port (d).
- All three interfaces use the same two-phase protocol:
  - Address phase in cycle N.
  - Data phase in cycle N+1, extended while wait is high.
- Sits between the core's imem/dmem buses and the memory/bus bridge.
- Adds zero latency when uncontended. A losing requester is buffered and stalled via its wait signal.
- Data port has fixed priority, with a starvation limit protecting the instruction port.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_D_STREAK, 4, consecutive contested d grants allowed before i must win; range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- imem_en  in  1  i address-phase request (tied high at integration).
- imem_addr  in  ADDR_WIDTH  i address.
- imem_wait  out  1  i data-phase stall.
- imem_rdata  out  DATA_WIDTH  i read data.
- imem_badmem_e  out  1  i access error, valid in data phase.
- dmem_en  in  1  d address-phase request.
- dmem_wen  in  1  d write.
- dmem_size  in  3  d access size.
- dmem_addr  in  ADDR_WIDTH  d address.
- dmem_wdata  in  DATA_WIDTH  d write data, presented in data phase.
- dmem_wait  out  1  d data-phase stall.
- dmem_rdata  out  DATA_WIDTH  d read data.
- dmem_badmem_e  out  1  d access error.
- mem_en  out  1  memory address-phase request.
- mem_wen  out  1  memory write.
- mem_size  out  3  memory access size.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data, data phase.
- mem_wait  in  1  memory data-phase stall.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_badmem_e  in  1  memory access error.

Behaviour:
- Per-port FSM (X = i or d), with states IDLE, HELD, DATA:
  - IDLE: no transfer pending. X_wait=0.
  - HELD: captured request not yet issued to memory. X_wait=1.
  - DATA: X owns the current memory data phase. X_wait=mem_wait. X_rdata=mem_rdata. X_badmem_e=mem_badmem_e.
- Port X is "ready" in IDLE, or in DATA with mem_wait=0. Only a ready port samples its live address-phase inputs; the requester holds its next request stable while X_wait=1.
- Candidate: X_cand = HELD | (ready & X_en). The request source is the hold register when HELD, otherwise the live inputs.
- Memory availability: mem_free = ~(some port in DATA & mem_wait). A grant is issued only when mem_free.
- Arbitration:
  - d wins a contested grant unless streak_cnt == MAX_D_STREAK, in which case i wins.
  - Uncontested: the sole candidate wins.
- streak_cnt (4 bits):
  - +1 on a d grant while i_cand.
  - Cleared on an i grant.
  - Saturates at MAX_D_STREAK.
- Grant cycle: mem_en=1, and mem_addr/mem_wen/mem_size come combinationally from the winner's source. i transfers drive mem_wen=0 and mem_size=3'b010. Winner -> DATA next cycle.
- Loser or blocked candidate:
  - If ready with a live request: capture addr/wen/size into its hold register and go to HELD.
  - If already HELD: stay HELD.
- No candidate, or not mem_free: mem_en=0; mem_addr/mem_wen/mem_size don't-care but held at last value.
- Data-phase owner is registered; mem_wdata = dmem_wdata when owner is d, else 0. Non-owner rdata = 0, badmem_e = 0.
- DATA with mem_wait=1: stay DATA, no new grants.
- DATA completing with no new request or grant: -> IDLE (or HELD if that port captured a new request).
- Back-to-back same-port transfers with mem_wait=0 issue every cycle at full throughput.
- Both ports requesting the same cycle: one granted, the other HELD. The HELD port is issued the next cycle if mem_free.
- Reset (including mid-transfer):
  - Both FSMs -> IDLE; hold registers invalidated; owner none; streak_cnt=0.
  - All outputs 0: waits, mem_en, rdata, badmem_e.
  - The outstanding memory transfer is abandoned; memory is reset in the same cycle.
- mem_en is 0 during reset.

Test Plan:
- Only imem_en=1, addr 0x100, 0x104, 0x108 over consecutive cycles, mem_wait=0 -> mem_addr follows the same cycle; imem_wait never asserted; rdata delivered at N+1.
- Same cycle dmem_en=1 write 0x2000 (wdata 0xDEADBEEF) and imem_en=1 addr 0x200 -> d granted at N; imem_wait=1 at N+1 while 0x200 issues; mem_wdata=0xDEADBEEF at N+1; i data at N+2.
- Continuous d and i requests, MAX_D_STREAK=4 -> grant sequence d,d,d,d,i repeating; streak_cnt returns to 0 after each i grant.
- mem_wait held high 3 cycles during a d read -> dmem_wait high 3 cycles; mem_en=0 throughout; a pending i request stays HELD and issues on the first cycle mem_wait=0.
- mem_badmem_e=1 in an i data phase -> imem_badmem_e=1 and dmem_badmem_e=0 in that cycle only.
- reset asserted while d is HELD and i is in DATA with mem_wait=1 -> next cycle both waits=0, mem_en=0, streak_cnt=0; a fresh request after reset is granted with zero added latency.

Source files
------------

// File: rtl/vscale_mem_arbiter.sv
// Instruction/data port arbiter in front of one pipelined backing memory.
// Zero added latency when uncontended; losers are held and stalled.
module vscale_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  imem_en,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_wait,
    output logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  imem_badmem_e,
    input  logic                  dmem_en,
    input  logic                  dmem_wen,
    input  logic [2:0]            dmem_size,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic                  dmem_wait,
    output logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_badmem_e,
    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wait,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_badmem_e
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_DATA
    } port_state_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [2:0] I_SIZE     = 3'b010;

    port_state_e           i_state_q, i_state_d;
    port_state_e           d_state_q, d_state_d;
    logic [ADDR_WIDTH-1:0] i_hold_addr_q, i_hold_addr_d;
    logic [ADDR_WIDTH-1:0] d_hold_addr_q, d_hold_addr_d;
    logic                  d_hold_wen_q, d_hold_wen_d;
    logic [2:0]            d_hold_size_q, d_hold_size_d;
    logic [3:0]            streak_q, streak_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  last_wen_q, last_wen_d;
    logic [2:0]            last_size_q, last_size_d;

    logic                  i_in_data, d_in_data;
    logic                  i_held, d_held;
    logic                  i_ready, d_ready;
    logic                  i_cand, d_cand;
    logic                  mem_free;
    logic                  i_turn;
    logic                  i_grant, d_grant;
    logic [ADDR_WIDTH-1:0] i_src_addr, d_src_addr;
    logic                  d_src_wen;
    logic [2:0]            d_src_size;

    assign i_in_data = (i_state_q == ST_DATA);
    assign d_in_data = (d_state_q == ST_DATA);
    assign i_held    = (i_state_q == ST_HELD);
    assign d_held    = (d_state_q == ST_HELD);

    // A port may take a new live request when it is idle or finishing.
    assign i_ready = (i_state_q == ST_IDLE) | (i_in_data & ~mem_wait);
    assign d_ready = (d_state_q == ST_IDLE) | (d_in_data & ~mem_wait);

    assign i_cand = i_held | (i_ready & imem_en);
    assign d_cand = d_held | (d_ready & dmem_en);

    // A stalled data phase blocks every new address phase.
    assign mem_free = ~((i_in_data | d_in_data) & mem_wait);

    // Data port normally wins; the streak limit hands one slot to i.
    assign i_turn  = (streak_q == STREAK_MAX);
    assign d_grant = mem_free & d_cand & (~i_cand | ~i_turn);
    assign i_grant = mem_free & i_cand & ~d_grant;

    assign i_src_addr = i_held ? i_hold_addr_q : imem_addr;
    assign d_src_addr = d_held ? d_hold_addr_q : dmem_addr;
    assign d_src_wen  = d_held ? d_hold_wen_q  : dmem_wen;
    assign d_src_size = d_held ? d_hold_size_q : dmem_size;

    // Memory address phase: winner's request, else hold the last values.
    always_comb begin
        mem_en      = ~reset & (i_grant | d_grant);
        mem_addr    = last_addr_q;
        mem_wen     = last_wen_q;
        mem_size    = last_size_q;
        last_addr_d = last_addr_q;
        last_wen_d  = last_wen_q;
        last_size_d = last_size_q;
        if (d_grant) begin
            mem_addr = d_src_addr;
            mem_wen  = d_src_wen;
            mem_size = d_src_size;
        end else if (i_grant) begin
            mem_addr = i_src_addr;
            mem_wen  = 1'b0;
            mem_size = I_SIZE;
        end
        if (i_grant | d_grant) begin
            last_addr_d = mem_addr;
            last_wen_d  = mem_wen;
            last_size_d = mem_size;
        end
    end

    // Data phase steering: only the owning port sees memory responses.
    always_comb begin
        imem_wait     = ~reset & (i_held | (i_in_data & mem_wait));
        dmem_wait     = ~reset & (d_held | (d_in_data & mem_wait));
        imem_rdata    = '0;
        imem_badmem_e = 1'b0;
        dmem_rdata    = '0;
        dmem_badmem_e = 1'b0;
        mem_wdata     = '0;
        if (~reset & i_in_data) begin
            imem_rdata    = mem_rdata;
            imem_badmem_e = mem_badmem_e;
        end
        if (~reset & d_in_data) begin
            dmem_rdata    = mem_rdata;
            dmem_badmem_e = mem_badmem_e;
            mem_wdata     = dmem_wdata;
        end
    end

    // Instruction port next state and hold-register capture.
    always_comb begin
        i_state_d     = i_state_q;
        i_hold_addr_d = i_hold_addr_q;
        if (i_grant) begin
            i_state_d = ST_DATA;
        end else if (i_held) begin
            i_state_d = ST_HELD;
        end else if (i_ready & imem_en) begin
            i_state_d     = ST_HELD;
            i_hold_addr_d = imem_addr;
        end else if (i_ready) begin
            i_state_d = ST_IDLE;
        end
    end

    // Data port next state and hold-register capture.
    always_comb begin
        d_state_d     = d_state_q;
        d_hold_addr_d = d_hold_addr_q;
        d_hold_wen_d  = d_hold_wen_q;
        d_hold_size_d = d_hold_size_q;
        if (d_grant) begin
            d_state_d = ST_DATA;
        end else if (d_held) begin
            d_state_d = ST_HELD;
        end else if (d_ready & dmem_en) begin
            d_state_d     = ST_HELD;
            d_hold_addr_d = dmem_addr;
            d_hold_wen_d  = dmem_wen;
            d_hold_size_d = dmem_size;
        end else if (d_ready) begin
            d_state_d = ST_IDLE;
        end
    end

    // Count contested d wins; any i grant restarts the streak.
    always_comb begin
        streak_d = streak_q;
        if (i_grant) begin
            streak_d = '0;
        end else if (d_grant & i_cand & (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // State, hold registers, streak counter and last address-phase values.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_state_q     <= ST_IDLE;
            d_state_q     <= ST_IDLE;
            i_hold_addr_q <= '0;
            d_hold_addr_q <= '0;
            d_hold_wen_q  <= 1'b0;
            d_hold_size_q <= '0;
            streak_q      <= '0;
            last_addr_q   <= '0;
            last_wen_q    <= 1'b0;
            last_size_q   <= '0;
        end else begin
            i_state_q     <= i_state_d;
            d_state_q     <= d_state_d;
            i_hold_addr_q <= i_hold_addr_d;
            d_hold_addr_q <= d_hold_addr_d;
            d_hold_wen_q  <= d_hold_wen_d;
            d_hold_size_q <= d_hold_size_d;
            streak_q      <= streak_d;
            last_addr_q   <= last_addr_d;
            last_wen_q    <= last_wen_d;
            last_size_q   <= last_size_d;
        end
    end

endmodule
